// File: rtl/forw_ctrl_unit_pkg.sv
// Shared definitions for the ID-stage forwarding controller: forw_mux select codes,
// default widths, the shadow-pipeline slot record and the source-priority helpers.
// Latency: n/a (definitions only). Backpressure: n/a.
package forw_ctrl_unit_pkg;

  localparam int FC_REGBITS = 5;
  localparam int FC_SELBITS = 2;
  localparam int FC_CNTBITS = 16;

  // forw_mux select codes
  typedef enum logic [1:0] {
    REGBNK = 2'b00,
    ALUSTG = 2'b01,
    MEMSTG = 2'b10,
    WBSTG  = 2'b11
  } fwd_sel_e;

  // One in-flight instruction as seen by the hazard logic.
  typedef struct packed {
    logic                  valid;
    logic [FC_REGBITS-1:0] rd;
    logic                  regwrite;
    logic                  memread;
  } slot_t;

  // Slot produces register x.
  function automatic logic slot_hit(input slot_t s, input logic [FC_REGBITS-1:0] x);
    return s.valid & s.regwrite & (s.rd == x);
  endfunction

  // Youngest producer wins. A load still in EX cannot be forwarded yet, so the
  // operand falls back to the register bank; the stall discards that value.
  function automatic fwd_sel_e pick_src(input logic live, input logic hit_ex,
                                        input logic hit_mem, input logic hit_wb,
                                        input logic ex_is_load);
    if (!live)        return REGBNK;
    else if (hit_ex)  return ex_is_load ? REGBNK : ALUSTG;
    else if (hit_mem) return MEMSTG;
    else if (hit_wb)  return WBSTG;
    else              return REGBNK;
  endfunction

endpackage

// File: rtl/forw_track_slot.sv
// One stage of the shadow pipeline: holds {valid, rd, regwrite, memread}.
// Latency: 1 cycle from d to q on an edge with load=1. Backpressure: load=0 holds the slot.
// Ports: clk, rst (async, active-high), load (advance), bubble (capture all-zero), d, q.
import forw_ctrl_unit_pkg::*;

module forw_track_slot (
  input  logic  clk,
  input  logic  rst,
  input  logic  load,
  input  logic  bubble,
  input  slot_t d,
  output slot_t q
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      q <= '0;
    end else if (load) begin
      q <= bubble ? '0 : d;
    end
  end

endmodule

// File: rtl/forw_ctrl_unit.sv
// ID-stage hazard/forwarding controller: forw_mux selects, load-use stall, stall counter.
// Latency: sel_a/sel_b/stall are combinational (0 cycles); slots and counter update on enabled edges.
// Backpressure: enable=0 freezes all state; stall holds PC/IF-ID for one enabled cycle per load-use pair.
// Ports: clk, rst, enable, flush, id_* (instruction in ID), clr_cnt -> sel_a, sel_b, stall, stall_count.
import forw_ctrl_unit_pkg::*;

module forw_ctrl_unit #(
  parameter int REGBITS = FC_REGBITS,
  parameter int SELBITS = FC_SELBITS,
  parameter int CNTBITS = FC_CNTBITS
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               enable,
  input  logic               flush,
  input  logic [REGBITS-1:0] id_rs,
  input  logic [REGBITS-1:0] id_rt,
  input  logic               id_use_rs,
  input  logic               id_use_rt,
  input  logic [REGBITS-1:0] id_rd,
  input  logic               id_regwrite,
  input  logic               id_memread,
  input  logic               clr_cnt,
  output logic [SELBITS-1:0] sel_a,
  output logic [SELBITS-1:0] sel_b,
  output logic               stall,
  output logic [CNTBITS-1:0] stall_count
);

  slot_t id_slot, ex_slot, mem_slot, wb_slot;
  logic  a_live, a_ex, a_mem, a_wb;
  logic  b_live, b_ex, b_mem, b_wb;
  logic  hazard;

  assign id_slot = '{valid: 1'b1, rd: id_rd, regwrite: id_regwrite, memread: id_memread};

  // A stalled or squashed ID instruction must not enter EX; a bubble goes in instead.
  forw_track_slot u_ex (
    .clk(clk), .rst(rst), .load(enable), .bubble(stall | flush), .d(id_slot), .q(ex_slot)
  );
  forw_track_slot u_mem (
    .clk(clk), .rst(rst), .load(enable), .bubble(1'b0), .d(ex_slot), .q(mem_slot)
  );
  forw_track_slot u_wb (
    .clk(clk), .rst(rst), .load(enable), .bubble(1'b0), .d(mem_slot), .q(wb_slot)
  );

  // r0 is hard-wired zero: never forwarded, never a hazard.
  always_comb begin
    a_live = id_use_rs && (id_rs != '0);
    b_live = id_use_rt && (id_rt != '0);
    a_ex   = a_live & slot_hit(ex_slot,  id_rs);
    a_mem  = a_live & slot_hit(mem_slot, id_rs);
    a_wb   = a_live & slot_hit(wb_slot,  id_rs);
    b_ex   = b_live & slot_hit(ex_slot,  id_rt);
    b_mem  = b_live & slot_hit(mem_slot, id_rt);
    b_wb   = b_live & slot_hit(wb_slot,  id_rt);
    hazard = (a_ex | b_ex) & ex_slot.memread;
    stall  = hazard & ~flush;
    sel_a  = SELBITS'(pick_src(a_live, a_ex, a_mem, a_wb, ex_slot.memread));
    sel_b  = SELBITS'(pick_src(b_live, b_ex, b_mem, b_wb, ex_slot.memread));
  end

  // Clear beats increment; the count sticks at all-ones.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      stall_count <= '0;
    end else if (enable) begin
      if (clr_cnt) begin
        stall_count <= '0;
      end else if (stall && (stall_count != {CNTBITS{1'b1}})) begin
        stall_count <= stall_count + 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_forw_ctrl_unit.sv
// Self-checking bench for forw_ctrl_unit: a table of per-cycle vectors plus hand
// sequences for counter saturation/clear and reset during a stall.
// A second instance with a 2-bit counter shares all inputs.
module tb_forw_ctrl_unit;

  logic       clk = 1'b0;
  logic       rst;
  logic       enable, flush, clr_cnt;
  logic [4:0] id_rs, id_rt, id_rd;
  logic       id_use_rs, id_use_rt, id_regwrite, id_memread;
  logic [1:0] sel_a, sel_b, sel_a_s, sel_b_s;
  logic       stall, stall_s;
  logic [15:0] stall_count;
  logic [1:0]  stall_count_s;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  forw_ctrl_unit dut (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .clr_cnt(clr_cnt), .sel_a(sel_a), .sel_b(sel_b), .stall(stall),
    .stall_count(stall_count)
  );

  forw_ctrl_unit #(.CNTBITS(2)) dut_s (
    .clk(clk), .rst(rst), .enable(enable), .flush(flush),
    .id_rs(id_rs), .id_rt(id_rt), .id_use_rs(id_use_rs), .id_use_rt(id_use_rt),
    .id_rd(id_rd), .id_regwrite(id_regwrite), .id_memread(id_memread),
    .clr_cnt(clr_cnt), .sel_a(sel_a_s), .sel_b(sel_b_s), .stall(stall_s),
    .stall_count(stall_count_s)
  );

  typedef struct packed {
    logic        en, fl, clr;
    logic [4:0]  rs, rt;
    logic        urs, urt;
    logic [4:0]  rd;
    logic        rw, mr;
    logic [1:0]  ea, eb;
    logic        es;
    logic [15:0] ec;
  } vec_t;

  localparam int NVEC = 26;
  vec_t vecs [NVEC];

  function automatic vec_t mk(input logic en, fl, clr, input logic [4:0] rs, rt,
                              input logic urs, urt, input logic [4:0] rd,
                              input logic rw, mr, input logic [1:0] ea, eb,
                              input logic es, input logic [15:0] ec);
    vec_t v;
    v = '{en, fl, clr, rs, rt, urs, urt, rd, rw, mr, ea, eb, es, ec};
    return v;
  endfunction

  task automatic chk(input string nm, input int idx, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s[%0d] got %0h expected %0h", nm, idx, act, exp);
    end
  endtask

  task automatic drive(input logic en, fl, clr, input logic [4:0] rs, rt,
                       input logic urs, urt, input logic [4:0] rd, input logic rw, mr);
    enable = en; flush = fl; clr_cnt = clr;
    id_rs = rs; id_rt = rt; id_use_rs = urs; id_use_rt = urt;
    id_rd = rd; id_regwrite = rw; id_memread = mr;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  initial begin
    // columns: en fl clr | rs rt urs urt | rd rw mr | sel_a sel_b stall count(before edge)
    vecs[0]  = mk(1,0,0,  3, 4,1,1,  0,0,0, 2'd0,2'd0,0,0);  // nothing in flight
    vecs[1]  = mk(1,0,0,  0, 0,0,0,  5,1,0, 2'd0,2'd0,0,0);  // issue r5 ALU op
    vecs[2]  = mk(1,0,0,  5, 0,1,0,  0,0,0, 2'd1,2'd0,0,0);  // r5 in EX
    vecs[3]  = mk(1,0,0,  5, 0,1,0,  0,0,0, 2'd2,2'd0,0,0);  // r5 in MEM
    vecs[4]  = mk(1,0,0,  5, 0,1,0,  0,0,0, 2'd3,2'd0,0,0);  // r5 in WB
    vecs[5]  = mk(1,0,0,  5, 0,1,0,  0,0,0, 2'd0,2'd0,0,0);  // r5 retired
    vecs[6]  = mk(1,0,0,  0, 0,0,0,  7,1,0, 2'd0,2'd0,0,0);  // r7 writer #1
    vecs[7]  = mk(1,0,0,  0, 0,0,0,  7,1,0, 2'd0,2'd0,0,0);  // r7 writer #2
    vecs[8]  = mk(1,0,0,  0, 7,0,1,  0,1,0, 2'd0,2'd1,0,0);  // EX and MEM hit: youngest; writes r0
    vecs[9]  = mk(1,0,0,  0, 0,0,1,  0,0,0, 2'd0,2'd0,0,0);  // rt=0 with r0 writer in EX
    vecs[10] = mk(1,0,0,  0, 7,0,1,  0,0,0, 2'd0,2'd3,0,0);  // r7 only in WB now
    vecs[11] = mk(1,0,0,  0, 0,0,0,  8,1,1, 2'd0,2'd0,0,0);  // load r8
    vecs[12] = mk(1,0,0,  8, 0,1,0,  9,1,0, 2'd0,2'd0,1,0);  // load-use: stall
    vecs[13] = mk(1,0,0,  8, 0,1,0,  9,1,0, 2'd2,2'd0,0,1);  // load in MEM: forward
    vecs[14] = mk(1,0,0,  0, 0,0,0,  0,0,0, 2'd0,2'd0,0,1);
    vecs[15] = mk(1,0,0,  0, 0,0,0, 10,1,1, 2'd0,2'd0,0,1);  // load r10
    vecs[16] = mk(1,1,0,  0,10,0,1, 10,1,1, 2'd0,2'd0,0,1);  // hazard + flush: no stall
    vecs[17] = mk(1,0,0,  0,10,0,1,  0,0,0, 2'd0,2'd2,0,1);  // flushed load never reached EX
    vecs[18] = mk(1,0,0,  0, 0,0,0, 11,1,1, 2'd0,2'd0,0,1);  // load r11
    vecs[19] = mk(0,0,0, 11, 0,1,0,  0,0,0, 2'd0,2'd0,1,1);  // frozen hazard
    vecs[20] = mk(0,0,0, 11, 0,1,0,  0,0,0, 2'd0,2'd0,1,1);
    vecs[21] = mk(0,0,0, 11, 0,1,0,  0,0,0, 2'd0,2'd0,1,1);
    vecs[22] = mk(1,0,0, 11, 0,1,0,  0,0,0, 2'd0,2'd0,1,1);  // enabled stall edge
    vecs[23] = mk(1,0,0, 11, 0,1,0,  0,0,0, 2'd2,2'd0,0,2);
    vecs[24] = mk(1,0,1,  0, 0,0,0,  0,0,0, 2'd0,2'd0,0,2);  // clear on this edge
    vecs[25] = mk(1,0,0,  0, 0,0,0,  0,0,0, 2'd0,2'd0,0,0);

    drive(1,0,0, 3,4,1,1, 0,0,0);
    rst = 1'b1;
    #2;
    chk("rst_sel_a", 0, 32'(sel_a), 32'd0);
    chk("rst_sel_b", 0, 32'(sel_b), 32'd0);
    chk("rst_stall", 0, 32'(stall), 32'd0);
    chk("rst_count", 0, 32'(stall_count), 32'd0);
    #10;
    rst = 1'b0;

    for (int i = 0; i < NVEC; i++) begin
      drive(vecs[i].en, vecs[i].fl, vecs[i].clr, vecs[i].rs, vecs[i].rt,
            vecs[i].urs, vecs[i].urt, vecs[i].rd, vecs[i].rw, vecs[i].mr);
      @(negedge clk);
      chk("sel_a", i, 32'(sel_a), 32'(vecs[i].ea));
      chk("sel_b", i, 32'(sel_b), 32'(vecs[i].eb));
      chk("stall", i, 32'(stall), 32'(vecs[i].es));
      chk("count", i, 32'(stall_count), 32'(vecs[i].ec));
      next_cycle();
    end

    // Five load-use pairs: 16-bit counter reaches 5, 2-bit counter sticks at 3.
    for (int p = 0; p < 5; p++) begin
      drive(1,0,0, 0,0,0,0, 12,1,1);
      next_cycle();
      drive(1,0,0, 12,0,1,0, 0,0,0);
      @(negedge clk);
      chk("sat_stall", p, 32'(stall_s), 32'd1);
      next_cycle();
      @(negedge clk);
      chk("sat_nostall", p, 32'(stall_s), 32'd0);
      next_cycle();
    end
    drive(1,0,0, 0,0,0,0, 0,0,0);
    @(negedge clk);
    chk("sat_count_s", 0, 32'(stall_count_s), 32'd3);
    chk("sat_count", 0, 32'(stall_count), 32'd5);

    // Clear.
    next_cycle();
    clr_cnt = 1'b1;
    next_cycle();
    clr_cnt = 1'b0;
    @(negedge clk);
    chk("clr_count_s", 0, 32'(stall_count_s), 32'd0);
    chk("clr_count", 0, 32'(stall_count), 32'd0);
    next_cycle();

    // One counted stall, then a second hazard interrupted by reset.
    drive(1,0,0, 0,0,0,0, 12,1,1);
    next_cycle();
    drive(1,0,0, 12,0,1,0, 0,0,0);
    next_cycle();
    drive(1,0,0, 0,0,0,0, 12,1,1);
    next_cycle();
    drive(1,0,0, 12,0,1,0, 0,0,0);
    @(negedge clk);
    chk("pre_rst_stall", 0, 32'(stall), 32'd1);
    chk("pre_rst_count", 0, 32'(stall_count), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst_mid_stall", 0, 32'(stall), 32'd0);
    chk("rst_mid_sel_a", 0, 32'(sel_a), 32'd0);
    chk("rst_mid_count", 0, 32'(stall_count), 32'd0);
    next_cycle();
    rst = 1'b0;
    @(negedge clk);
    chk("post_rst_stall", 0, 32'(stall), 32'd0);
    chk("post_rst_sel_a", 0, 32'(sel_a), 32'd0);
    next_cycle();

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
